irq_sequencer: RTL
==================

// Module: irq_sequencer
// PURPOSE
//  Collects peripheral interrupt requests, selects one by fixed priority and sequences it into the
//  pipeline. Drives the control unit's IRQ input only at a safe ID-stage point: real instruction,
//  not a branch/jump shadow, no stall, user mode. Blocks further interrupts until the handler
//  returns via jr $k0. Sits between the peripheral bus and the ID-stage control unit.
// PARAMETERS
//  NUM_SRC   4                 number of interrupt sources; CAUSE_W = $clog2(NUM_SRC)
//  MASK_RST  {NUM_SRC{1'b1}}   reset value of the enable mask
// PORTS
//  clk             in   1        system clock, rising edge
//  reset           in   1        asynchronous, active-low reset
//  irq_src         in   NUM_SRC  level requests from peripherals
//  mask_wr         in   1        write strobe for enable mask
//  mask_wdata      in   NUM_SRC  new mask value; 1 = source enabled
//  id_valid        in   1        ID stage holds a real instruction (not a bubble)
//  id_shadow       in   1        ID instruction follows a taken branch/jump (delay/flush shadow)
//  stall           in   1        pipeline held this cycle
//  kernel_mode     in   1        PC[31] of the ID instruction
//  eret            in   1        ID decodes jr $k0 in kernel mode, not stalled
//  irq_to_cu       out  1        IRQ to control unit, one-cycle pulse
//  flush_if        out  1        flush IF/ID register; equals irq_to_cu
//  irq_cause       out  CAUSE_W  index of the source being serviced
//  pending         out  NUM_SRC  sticky pending flags
//  mask            out  NUM_SRC  current enable mask
//  in_service      out  1        handler active
//  irq_count       out  16       count of taken interrupts
// BEHAVIOUR
//  - Reset (async, reset=0): state=IDLE, pending=0, mask=MASK_RST, irq_cause=0, irq_count=0,
//    irq_to_cu=flush_if=in_service=0.
//  - pending[i] sets every cycle irq_src[i]=1. It clears only when source i is taken.
//    If set and clear coincide, set wins.
//  - eligible = pending & mask. winner = lowest set index of eligible.
//  - FSM:
//    IDLE:    eligible!=0 && !kernel_mode -> ARMED.
//    ARMED:   eligible==0 -> IDLE (e.g. masked off);
//             else if id_valid && !id_shadow && !stall && !kernel_mode -> TAKE.
//    TAKE:    1 cycle; irq_to_cu=flush_if=1; irq_cause<=winner; pending[winner] cleared;
//             irq_count+1 -> SERVICE.
//    SERVICE: in_service=1; eret -> IDLE.
//  - The winner is sampled at the TAKE cycle, with eligible evaluated on that cycle's pre-write mask.
//    A mask_wr on the same cycle takes effect next cycle.
//  - eret outside SERVICE is ignored. irq_cause holds its value until the next TAKE.
//  - Latency: request to irq_to_cu is >= 3 cycles (latch, ARMED, TAKE) when the pipeline is safe.
//  - irq_count wraps from 16'hFFFF to 0.
//  - Reset asserted mid-operation returns to reset values immediately. Any in-flight handler is abandoned.
//  - All outputs are registered except flush_if, which is decoded from the TAKE state.
// CONFIGURATION
//  IRQ_COUNT_EN defined:     irq_count is implemented as described.
//  IRQ_COUNT_EN not defined: no counter logic; irq_count tied to 16'h0.
// TESTING
//  1. Reset, then irq_src=4'b0100 with the pipeline safe
//     -> irq_to_cu pulse 3 cycles later; irq_cause=2; pending[2]=0 (src low); in_service=1.
//  2. irq_src=4'b1010 together, safe
//     -> cause=1 taken first. After eret with src[3] still high -> cause=3 taken next.
//  3. Request while id_shadow=1 for 4 cycles, then 0
//     -> no pulse during the shadow; pulse the cycle after the shadow drops.
//  4. In SERVICE, irq_src=4'b0001 -> no pulse until eret. Then a pulse with cause=0.
//  5. In ARMED, mask_wr with mask_wdata=0 -> IDLE, no pulse. Restore mask 4'hF -> taken.
//  6. Reset pulsed low during SERVICE -> state IDLE, pending=0, irq_count=0 (IRQ_COUNT_EN),
//     mask=4'hF.

Source files
------------

// File: rtl/irq_sequencer.sv
// irq_sequencer: latches peripheral interrupt requests, picks the lowest-index
// enabled one and hands it to the ID-stage control unit at a safe point.
// Build option: define IRQ_COUNT_EN to implement the taken-interrupt counter;
// otherwise irq_count is tied to zero.
module irq_sequencer #(
  parameter int unsigned NUM_SRC = 4,
  parameter logic [NUM_SRC-1:0] MASK_RST = '1,
  localparam int unsigned CAUSE_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               mask_wr,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               id_valid,
  input  logic               id_shadow,
  input  logic               stall,
  input  logic               kernel_mode,
  input  logic               eret,
  output logic               irq_to_cu,
  output logic               flush_if,
  output logic [CAUSE_W-1:0] irq_cause,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask,
  output logic               in_service,
  output logic [CNT_W-1:0]   irq_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    TAKE    = 2'd2,
    SERVICE = 2'd3
  } state_t;

  state_t               state;
  state_t               state_n;
  logic [NUM_SRC-1:0]   eligible;
  logic [NUM_SRC-1:0]   lowest;
  logic [NUM_SRC-1:0]   take_clr;
  logic [CAUSE_W-1:0]   winner;
  logic                 safe_point;

  assign eligible   = pending & mask;
  // Isolate the lowest set bit: the fixed-priority winner as a one-hot vector.
  assign lowest     = eligible & (~eligible + NUM_SRC'(1));
  assign take_clr   = (state == TAKE) ? lowest : '0;
  assign safe_point = id_valid && !id_shadow && !stall && !kernel_mode;
  assign flush_if   = (state == TAKE);

  // Encode the lowest eligible index (scan from the top so the lowest wins).
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = CAUSE_W'(i);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state decode.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (eligible != '0 && !kernel_mode) state_n = ARMED;
      ARMED: begin
        if (eligible == '0) state_n = IDLE;
        else if (safe_point) state_n = TAKE;
      end
      TAKE:    state_n = SERVICE;
      SERVICE: if (eret) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Registered handshake outputs, decoded from the upcoming state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_to_cu  <= 1'b0;
      in_service <= 1'b0;
    end else begin
      irq_to_cu  <= (state_n == TAKE);
      in_service <= (state_n == SERVICE);
    end
  end

  // Sticky pending flags; a new request beats the clear of a taken source.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= (pending & ~take_clr) | irq_src;
  end

  // Enable mask; a write lands after the current cycle's arbitration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       mask <= MASK_RST;
    else if (mask_wr) mask <= mask_wdata;
  end

  // Cause of the interrupt being serviced, held until the next take.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              irq_cause <= '0;
    else if (state == TAKE) irq_cause <= winner;
  end

`ifdef IRQ_COUNT_EN
  // Taken-interrupt counter, wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              irq_count <= '0;
    else if (state == TAKE) irq_count <= irq_count + CNT_W'(1);
  end
`else
  assign irq_count = '0;
`endif

endmodule
